// File: rtl/bf16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bf16_pkg
// Description : Shared BFloat16 types and constants for the pipelined
//               subtractor: field widths, canonical NaN, largest finite
//               exponent, result/flag structs and the stage-1 payload.
// Revision    : 1.0 - initial release
// ============================================================================
package bf16_pkg;

  localparam int E = 8;  // exponent width
  localparam int M = 7;  // stored mantissa width

  typedef struct packed {
    logic         s;
    logic [E-1:0] e;
    logic [M-1:0] m;
  } bf16_t;

  typedef struct packed {
    logic nv;  // NaN produced
    logic of;  // result clamped to largest finite
    logic uf;  // nonzero result flushed to zero
  } bf16_flags_t;

  localparam bf16_t        BF16_QNAN    = 16'h7FFF;
  localparam logic [E-1:0] BF16_MAX_EXP = 8'hFE;

  // Everything stage 2 needs. xs/ys are {hidden, mantissa, guard, round, sticky};
  // x is always the operand of larger magnitude, so stage 2 never goes negative.
  typedef struct packed {
    logic         special;
    bf16_t        spec_res;
    bf16_flags_t  spec_flags;
    logic         sx;
    logic [E-1:0] ex;
    logic         eff_sub;
    logic [M+3:0] xs;
    logic [M+3:0] ys;
  } s1_payload_t;

  function automatic bf16_t bf16_pack(input logic s, input logic [E-1:0] e,
                                      input logic [M-1:0] m);
    bf16_t r;
    r.s = s;
    r.e = e;
    r.m = m;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bf16_align_shift.sv
`default_nettype none
// ============================================================================
// Module      : bf16_align_shift
// Description : Sticky-preserving right shifter for the smaller operand.
//               Output is {hidden, mantissa, guard, round, sticky}; sticky is
//               the OR of every bit shifted past the round position.
// Ports       : sig     [M:0]   {hidden, mantissa} of the smaller operand
//               shamt   [E-1:0] exponent difference
//               aligned [M+3:0] aligned significand with G/R/S
// Revision    : 1.0 - initial release
// ============================================================================
module bf16_align_shift
  import bf16_pkg::*;
(
  input  logic [M:0]   sig,
  input  logic [E-1:0] shamt,
  output logic [M+3:0] aligned
);

  localparam int           FW     = M + 3;  // hidden + mantissa + guard + round
  localparam logic [E-1:0] MAX_SH = E'(FW);

  logic [E-1:0]    w_sh;
  logic [2*FW-1:0] w_win;

  // Any shift of FW or more pushes everything into sticky, so clamp there.
  assign w_sh    = (shamt > MAX_SH) ? MAX_SH : shamt;
  assign w_win   = {sig, 2'b00, {FW{1'b0}}} >> w_sh;
  assign aligned = {w_win[2*FW-1:FW], |w_win[FW-1:0]};

endmodule
`default_nettype wire

// File: rtl/lzc.sv
`default_nettype none
// ============================================================================
// Module      : lzc
// Description : Leading-zero counter. zcount = number of zeros above the most
//               significant set bit of din; W when din is all zeros.
// Ports       : din    [W-1:0]  input vector
//               zcount [CW-1:0] leading-zero count
// Revision    : 1.0 - initial release
// ============================================================================
module lzc #(
  parameter  int W  = 16,
  localparam int CW = $clog2(W) + 1
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] zcount
);

  // Scanning upward lets the highest set bit win the last assignment.
  always_comb begin
    zcount = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) zcount = CW'(W - 1 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bf16_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bf16_sub_pipe
// Description : Two-stage pipelined BFloat16 subtractor c = a - b, round
//               toward zero, flush-to-zero, valid/ready on both sides.
//               Stage 1: negate b, swap, align, classify specials.
//               Stage 2: add/subtract, normalise, clamp, pack.
// Ports       : clk, nreset (async active-low)
//               valid_i/ready_o      operand handshake
//               sa_i/ea_i/ma_i       operand a
//               sb_i/eb_i/mb_i       operand b
//               valid_o/ready_i      result handshake
//               s_o/e_o/m_o          result
//               nv_o/of_o/uf_o       invalid / overflow / underflow flags
// Revision    : 1.0 - initial release
// ============================================================================
module bf16_sub_pipe
  import bf16_pkg::*;
(
  input  logic         clk,
  input  logic         nreset,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         sa_i,
  input  logic [E-1:0] ea_i,
  input  logic [M-1:0] ma_i,
  input  logic         sb_i,
  input  logic [E-1:0] eb_i,
  input  logic [M-1:0] mb_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         s_o,
  output logic [E-1:0] e_o,
  output logic [M-1:0] m_o,
  output logic         nv_o,
  output logic         of_o,
  output logic         uf_o
);

  localparam int LZW = 16;

  // ---------------- handshake ----------------
  logic r_v1;
  logic w_load1, w_load2, w_accept;

  assign w_load2  = ~valid_o | ready_i;
  assign w_load1  = ~r_v1 | w_load2;
  assign ready_o  = w_load1;
  assign w_accept = valid_i & ready_o;

  // ---------------- stage 1: classify / swap / align ----------------
  logic         w_sbn, w_a_zero, w_b_zero, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic         w_a_ge_b;
  logic [M-1:0] w_ma, w_mb, w_mx, w_my;
  logic [E-1:0] w_ex, w_ey;
  logic [M+3:0] w_ys;
  s1_payload_t  w_s1, r_s1;

  assign w_sbn    = ~sb_i;
  assign w_a_zero = (ea_i == '0);
  assign w_b_zero = (eb_i == '0);
  assign w_a_nan  = (&ea_i) & (|ma_i);
  assign w_b_nan  = (&eb_i) & (|mb_i);
  assign w_a_inf  = (&ea_i) & ~(|ma_i);
  assign w_b_inf  = (&eb_i) & ~(|mb_i);

  // A zero exponent means zero, so its mantissa must not influence the swap.
  assign w_ma     = w_a_zero ? '0 : ma_i;
  assign w_mb     = w_b_zero ? '0 : mb_i;
  assign w_a_ge_b = {ea_i, w_ma} >= {eb_i, w_mb};

  assign w_ex = w_a_ge_b ? ea_i : eb_i;
  assign w_mx = w_a_ge_b ? w_ma : w_mb;
  assign w_ey = w_a_ge_b ? eb_i : ea_i;
  assign w_my = w_a_ge_b ? w_mb : w_ma;

  bf16_align_shift u_align (
    .sig     ({w_ey != '0, w_my}),
    .shamt   (w_ex - w_ey),
    .aligned (w_ys)
  );

  always_comb begin
    w_s1         = '0;
    w_s1.sx      = w_a_ge_b ? sa_i : w_sbn;
    w_s1.ex      = w_ex;
    w_s1.eff_sub = sa_i ^ w_sbn;
    w_s1.xs      = {w_ex != '0, w_mx, 3'b000};
    w_s1.ys      = w_ys;
    if (w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (sa_i == sb_i))) begin
      w_s1.special       = 1'b1;
      w_s1.spec_res      = BF16_QNAN;
      w_s1.spec_flags.nv = 1'b1;
    end else if (w_a_inf) begin
      w_s1.special  = 1'b1;
      w_s1.spec_res = bf16_pack(sa_i, '1, '0);
    end else if (w_b_inf) begin
      w_s1.special  = 1'b1;
      w_s1.spec_res = bf16_pack(w_sbn, '1, '0);
    end else if (w_a_zero & w_b_zero) begin
      // Only (-0) + (-0) keeps a negative sign.
      w_s1.special  = 1'b1;
      w_s1.spec_res = bf16_pack(sa_i & w_sbn, '0, '0);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_v1 <= 1'b0;
      r_s1 <= '0;
    end else if (w_load1) begin
      r_v1 <= w_accept;
      if (w_accept) r_s1 <= w_s1;
    end
  end

  // ---------------- stage 2: add / normalise / pack ----------------
  logic        [M+4:0]         w_sum, w_norm;
  logic        [$clog2(LZW):0] w_lz;
  logic signed [E+1:0]         w_exp;
  bf16_t                       w_res;
  bf16_flags_t                 w_flags;
  logic                        w_unused;

  assign w_sum = r_s1.eff_sub ? ({1'b0, r_s1.xs} - {1'b0, r_s1.ys})
                              : ({1'b0, r_s1.xs} + {1'b0, r_s1.ys});

  lzc #(.W(LZW)) u_lzc (
    .din    ({w_sum, {(LZW - (M + 5)){1'b0}}}),
    .zcount (w_lz)
  );

  // Hidden bit sits one below the carry bit, so lz==1 means "already normal".
  assign w_norm   = w_sum << w_lz;
  assign w_exp    = $signed({2'b00, r_s1.ex}) + 10'sd1 - $signed({5'b00000, w_lz});
  assign w_unused = ^{w_norm[M+4], w_norm[3:0]};

  always_comb begin
    w_res   = '0;
    w_flags = '0;
    if (r_s1.special) begin
      w_res   = r_s1.spec_res;
      w_flags = r_s1.spec_flags;
    end else if (w_sum == '0) begin
      w_res = '0;  // exact cancellation is +0
    end else if (w_exp >= 10'sd255) begin
      w_res      = bf16_pack(r_s1.sx, BF16_MAX_EXP, '1);
      w_flags.of = 1'b1;
    end else if (w_exp <= 10'sd0) begin
      w_res      = bf16_pack(r_s1.sx, '0, '0);
      w_flags.uf = 1'b1;
    end else begin
      w_res = bf16_pack(r_s1.sx, w_exp[E-1:0], w_norm[M+3 -: M]);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid_o <= 1'b0;
      s_o     <= 1'b0;
      e_o     <= '0;
      m_o     <= '0;
      nv_o    <= 1'b0;
      of_o    <= 1'b0;
      uf_o    <= 1'b0;
    end else if (w_load2) begin
      valid_o <= r_v1;
      if (r_v1) begin
        s_o  <= w_res.s;
        e_o  <= w_res.e;
        m_o  <= w_res.m;
        nv_o <= w_flags.nv;
        of_o <= w_flags.of;
        uf_o <= w_flags.uf;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bf16_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_bf16_sub_pipe
// Description : Self-checking bench for bf16_sub_pipe. Expected results come
//               from an exact wide-integer model of a - b truncated toward
//               zero; directed vectors also carry hand-computed answers that
//               pin the model. A negedge monitor scoreboards every transfer
//               and checks that stalled outputs hold.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bf16_sub_pipe;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic       sa_i = 1'b0, sb_i = 1'b0;
  logic [7:0] ea_i = '0, eb_i = '0;
  logic [6:0] ma_i = '0, mb_i = '0;
  logic       valid_o;
  logic       ready_i = 1'b1;
  logic       s_o;
  logic [7:0] e_o;
  logic [6:0] m_o;
  logic       nv_o, of_o, uf_o;

  int checks = 0;
  int errors = 0;
  int outs   = 0;

  // queue entry: {a[15:0], b[15:0], result[15:0], {nv,of,uf}}
  logic [50:0] exp_q[$];
  logic [50:0] vecs[0:14];

  bf16_sub_pipe dut (
    .clk(clk), .nreset(nreset), .valid_i(valid_i), .ready_o(ready_o),
    .sa_i(sa_i), .ea_i(ea_i), .ma_i(ma_i),
    .sb_i(sb_i), .eb_i(eb_i), .mb_i(mb_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .s_o(s_o), .e_o(e_o), .m_o(m_o),
    .nv_o(nv_o), .of_o(of_o), .uf_o(uf_o)
  );

  always #5 clk = ~clk;

  // Exact model: finite magnitudes as integers scaled by 2^133, so every
  // difference is exact; then truncate to 8 significant bits.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b);
    logic         sa, sb, sr;
    logic [7:0]   ea, eb;
    logic [6:0]   ma, mb;
    logic [263:0] xa, xb, mag, t;
    int           p, er;
    {sa, ea, ma} = a;
    {sb, eb, mb} = b;
    if ((ea == 8'hFF && ma != 0) || (eb == 8'hFF && mb != 0) ||
        (ea == 8'hFF && eb == 8'hFF && sa == sb))
      return {16'h7FFF, 3'b100};
    if (ea == 8'hFF) return {sa, 8'hFF, 7'h00, 3'b000};
    if (eb == 8'hFF) return {~sb, 8'hFF, 7'h00, 3'b000};
    if (ea == 0 && eb == 0) return {sa & ~sb, 15'h0000, 3'b000};
    xa = (ea == 0) ? '0 : ({256'd0, 1'b1, ma} << (ea - 8'd1));
    xb = (eb == 0) ? '0 : ({256'd0, 1'b1, mb} << (eb - 8'd1));
    if (sa == ~sb) begin
      mag = xa + xb; sr = sa;
    end else if (xa >= xb) begin
      mag = xa - xb; sr = sa;
    end else begin
      mag = xb - xa; sr = ~sb;
    end
    if (mag == 0) return 19'd0;
    p = 0;
    for (int i = 0; i < 264; i++) if (mag[i]) p = i;
    er = p - 6;
    if (er >= 255) return {sr, 8'hFE, 7'h7F, 3'b010};
    if (er <= 0)   return {sr, 15'h0000, 3'b001};
    t = mag >> (p - 7);
    return {sr, er[7:0], t[6:0], 3'b000};
  endfunction

  // Monitor: handshake values seen at the negedge are the ones the next
  // rising edge acts on, since inputs only move just after a rising edge.
  logic        stall_prev = 1'b0;
  logic [18:0] prev_out;
  logic [50:0] ent;
  always @(negedge clk) begin
    if (!nreset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!valid_o || {s_o, e_o, m_o, nv_o, of_o, uf_o} != prev_out) begin
          errors++;
          $display("FAIL hold: got valid=%b out=%h, required valid=1 out=%h",
                   valid_o, {s_o, e_o, m_o, nv_o, of_o, uf_o}, prev_out);
        end
      end
      if (valid_o && ready_i) begin
        checks++;
        outs++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected output %h flags %b, required none",
                   {s_o, e_o, m_o}, {nv_o, of_o, uf_o});
        end else begin
          ent = exp_q.pop_front();
          if ({s_o, e_o, m_o, nv_o, of_o, uf_o} != ent[18:0]) begin
            errors++;
            $display("FAIL result %h-%h: got %h flags %b, required %h flags %b",
                     ent[50:35], ent[34:19], {s_o, e_o, m_o}, {nv_o, of_o, uf_o},
                     ent[18:3], ent[2:0]);
          end
        end
      end
      stall_prev = valid_o && !ready_i;
      prev_out   = {s_o, e_o, m_o, nv_o, of_o, uf_o};
      if (valid_i && ready_o)
        exp_q.push_back({sa_i, ea_i, ma_i, sb_i, eb_i, mb_i,
                         model({sa_i, ea_i, ma_i}, {sb_i, eb_i, mb_i})});
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Present an operand pair; returns at posedge+1 after it was accepted.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    {sa_i, ea_i, ma_i} = a;
    {sb_i, eb_i, mb_i} = b;
    valid_i = 1'b1;
    @(negedge clk);
    while (!ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL accept timeout for %h-%h: ready_o stayed 0", a, b);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain outstanding", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  int out_base;
  logic [18:0] m;

  initial begin
    vecs[0]  = {16'h4040, 16'h3F80, 16'h4000, 3'b000};
    vecs[1]  = {16'h3F80, 16'h3F80, 16'h0000, 3'b000};
    vecs[2]  = {16'h3F80, 16'h3B00, 16'h3F7F, 3'b000};
    vecs[3]  = {16'h3F80, 16'hBF80, 16'h4000, 3'b000};
    vecs[4]  = {16'h7F80, 16'h7F80, 16'h7FFF, 3'b100};
    vecs[5]  = {16'h7F80, 16'hFF80, 16'h7F80, 3'b000};
    vecs[6]  = {16'h7FC0, 16'h3F80, 16'h7FFF, 3'b100};
    vecs[7]  = {16'h7F7F, 16'hFF7F, 16'h7F7F, 3'b010};
    vecs[8]  = {16'h0080, 16'h0081, 16'h8000, 3'b001};
    vecs[9]  = {16'h0040, 16'h3F80, 16'hBF80, 3'b000};
    vecs[10] = {16'h8000, 16'h0000, 16'h8000, 3'b000};
    vecs[11] = {16'h0000, 16'h0000, 16'h0000, 3'b000};
    vecs[12] = {16'h3F80, 16'h7F80, 16'hFF80, 3'b000};
    vecs[13] = {16'h3F80, 16'h4040, 16'hC000, 3'b000};
    vecs[14] = {16'h4000, 16'h3F80, 16'h3F80, 3'b000};

    // Pin the model to the hand-computed answers.
    for (int k = 0; k < 15; k++) begin
      m = model(vecs[k][50:35], vecs[k][34:19]);
      check($sformatf("model %h-%h", vecs[k][50:35], vecs[k][34:19]), {13'd0, m}, {13'd0, vecs[k][18:0]});
    end

    // Reset state.
    #12;
    check("reset outputs", {valid_o, s_o, e_o, m_o, nv_o, of_o, uf_o}, 0);
    check("reset ready_o", ready_o, 1);
    @(posedge clk);
    #2;
    nreset = 1'b1;
    @(posedge clk);
    #1;

    // Single op on an empty pipe: valid_o two cycles after acceptance.
    issue(vecs[0][50:35], vecs[0][34:19]);
    @(negedge clk);
    check("latency cycle1 valid_o", valid_o, 0);
    @(negedge clk);
    check("latency cycle2 valid_o", valid_o, 1);
    drain();

    // All vectors back to back, downstream always ready.
    for (int k = 1; k < 15; k++) issue(vecs[k][50:35], vecs[k][34:19]);
    drain();

    // All vectors again with downstream ready toggling.
    fork
      begin
        for (int k = 0; k < 15; k++) issue(vecs[k][50:35], vecs[k][34:19]);
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(posedge clk);
          #1;
          ready_i = (c % 3) != 1;
        end
        ready_i = 1'b1;
      end
    join
    drain();

    // Back-pressure: 4 ops, downstream stalled for 5 cycles.
    out_base = outs;
    ready_i  = 1'b0;
    fork
      begin
        issue(16'h4040, 16'h3F80);
        issue(16'h3F80, 16'h3B00);
        issue(16'h7F7F, 16'hFF7F);
        issue(16'h4000, 16'h3F80);
      end
      begin
        repeat (2) @(posedge clk);
        #2;
        check("ready_o after 2 accepted", ready_o, 0);
        repeat (3) @(posedge clk);
        #1;
        ready_i = 1'b1;
      end
    join
    drain();
    check("backpressure output count", outs - out_base, 4);

    // Asynchronous reset with two ops in flight.
    ready_i = 1'b0;
    issue(16'h4040, 16'h3F80);
    issue(16'h3F80, 16'hBF80);
    #1;
    nreset = 1'b0;
    exp_q.delete();
    #1;
    check("async reset outputs", {valid_o, s_o, e_o, m_o, nv_o, of_o, uf_o}, 0);
    check("async reset ready_o", ready_o, 1);
    repeat (2) @(posedge clk);
    #2;
    nreset  = 1'b1;
    ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("no stale output after reset", valid_o, 0);
    end
    @(posedge clk);
    #1;
    out_base = outs;
    issue(16'h3F80, 16'h4040);
    drain();
    check("post-reset output count", outs - out_base, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
